// File: rtl/jtag_seq_master.sv
// JTAG sequence master: shifts up to MAX_BITS of TMS/TDI per command on a divided TCK,
// captures TDO on each rising TCK edge, and can alternatively issue a TRST pulse.
module jtag_seq_master #(
    parameter int MAX_BITS = 32,
    parameter int LEN_W    = $clog2(MAX_BITS + 1),
    parameter int DIV_W    = 6
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [LEN_W-1:0]    cmd_len_i,
    input  logic [MAX_BITS-1:0] cmd_tms_i,
    input  logic [MAX_BITS-1:0] cmd_tdi_i,
    input  logic                cmd_trst_i,
    input  logic [DIV_W-1:0]    half_period_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [MAX_BITS-1:0] rsp_tdo_o,
    output logic [LEN_W-1:0]    rsp_len_o,
    output logic                busy_o,
    output logic                tck_o,
    output logic                tms_o,
    output logic                tdi_o,
    output logic                trst_o,
    input  logic                tdo_i
);

    // Handshakes: a transfer happens on a rising clk_i edge where valid and ready are both high;
    // the command side is ready only in IDLE, the response is held until rsp_ready_i.
    typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_TRST, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    bit_q, bit_d;
    logic [DIV_W-1:0]    half_q, half_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [MAX_BITS-1:0] tms_sr_q, tms_sr_d;
    logic [MAX_BITS-1:0] tdi_sr_q, tdi_sr_d;
    logic [MAX_BITS-1:0] tdo_q, tdo_d;
    logic                tck_q, tck_d;
    logic                trst_q, trst_d;
    logic [LEN_W-1:0]    len_clip;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        bit_d    = bit_q;
        half_d   = half_q;
        cnt_d    = cnt_q;
        tms_sr_d = tms_sr_q;
        tdi_sr_d = tdi_sr_q;
        tdo_d    = tdo_q;
        tck_d    = tck_q;
        trst_d   = trst_q;
        len_clip = (cmd_len_i > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : cmd_len_i;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    half_d = (half_period_i == '0) ? DIV_W'(1) : half_period_i;
                    cnt_d  = half_d - 1'b1;
                    bit_d  = '0;
                    tdo_d  = '0;
                    tck_d  = 1'b0;
                    if (cmd_trst_i) begin
                        len_d   = '0;
                        trst_d  = 1'b0;
                        state_d = S_TRST;
                    end else begin
                        len_d   = len_clip;
                        state_d = S_LOW;
                        // Zero-length commands leave the TMS/TDI lines untouched.
                        if (len_clip != '0) begin
                            tms_sr_d = cmd_tms_i;
                            tdi_sr_d = cmd_tdi_i;
                        end
                    end
                end
            end
            S_LOW: begin
                if (len_q == '0) begin
                    state_d = S_RESP;
                end else if (cnt_q == '0) begin
                    tck_d   = 1'b1;
                    tdo_d   = tdo_q | (MAX_BITS'(tdo_i) << bit_q);
                    cnt_d   = half_q - 1'b1;
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HIGH: begin
                if (cnt_q == '0) begin
                    tck_d = 1'b0;
                    if (bit_q == len_q - 1'b1) begin
                        state_d = S_RESP;
                    end else begin
                        bit_d    = bit_q + 1'b1;
                        tms_sr_d = tms_sr_q >> 1;
                        tdi_sr_d = tdi_sr_q >> 1;
                        cnt_d    = half_q - 1'b1;
                        state_d  = S_LOW;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_TRST: begin
                // Two half periods: bit_q marks whether the first one has elapsed.
                if (cnt_q == '0) begin
                    if (bit_q != '0) begin
                        trst_d  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        bit_d = LEN_W'(1);
                        cnt_d = half_q - 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            bit_q    <= '0;
            half_q   <= DIV_W'(1);
            cnt_q    <= '0;
            tms_sr_q <= '1;
            tdi_sr_q <= '0;
            tdo_q    <= '0;
            tck_q    <= 1'b0;
            trst_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            bit_q    <= bit_d;
            half_q   <= half_d;
            cnt_q    <= cnt_d;
            tms_sr_q <= tms_sr_d;
            tdi_sr_q <= tdi_sr_d;
            tdo_q    <= tdo_d;
            tck_q    <= tck_d;
            trst_q   <= trst_d;
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE) && !rst_i;
    assign busy_o      = (state_q != S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_tdo_o   = tdo_q;
    assign rsp_len_o   = len_q;
    assign tck_o       = tck_q;
    assign tms_o       = tms_sr_q[0];
    assign tdi_o       = tdi_sr_q[0];
    assign trst_o      = trst_q;

endmodule

// File: tb/tb_jtag_seq_master.sv
// Randomized bench for jtag_seq_master against a waveform model derived from the
// command timing rules (TCK high in the second half of each 2H window).
module tb_jtag_seq_master;
    localparam int MB = 32;
    localparam int LW = 6;
    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [LW-1:0] cmd_len_i = '0;
    logic [MB-1:0] cmd_tms_i = '0;
    logic [MB-1:0] cmd_tdi_i = '0;
    logic          cmd_trst_i = 1'b0;
    logic [DW-1:0] half_period_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [MB-1:0] rsp_tdo_o;
    logic [LW-1:0] rsp_len_o;
    logic          busy_o, tck_o, tms_o, tdi_o, trst_o;
    logic          tdo_i = 1'b0;

    int total = 0;
    int bad = 0;
    logic [MB-1:0] exp_q[$];

    jtag_seq_master #(.MAX_BITS(MB), .LEN_W(LW), .DIV_W(DW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_len_i(cmd_len_i), .cmd_tms_i(cmd_tms_i), .cmd_tdi_i(cmd_tdi_i),
        .cmd_trst_i(cmd_trst_i), .half_period_i(half_period_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_tdo_o(rsp_tdo_o), .rsp_len_o(rsp_len_o), .busy_o(busy_o),
        .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .trst_o(trst_o), .tdo_i(tdo_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready_o && n < 200) begin
            step();
            n++;
        end
        check_eq("cmd_ready_wait", cmd_ready_o, 1'b1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_tck"}, tck_o, 1'b0);
        check_eq({pfx, "_tms"}, tms_o, 1'b1);
        check_eq({pfx, "_tdi"}, tdi_o, 1'b0);
        check_eq({pfx, "_trst"}, trst_o, 1'b1);
        check_eq({pfx, "_rsp_valid"}, rsp_valid_o, 1'b0);
        check_eq({pfx, "_rsp_tdo"}, rsp_tdo_o, '0);
        check_eq({pfx, "_rsp_len"}, rsp_len_o, '0);
        check_eq({pfx, "_busy"}, busy_o, 1'b0);
    endtask

    task automatic offer(input int len_in, input logic [MB-1:0] tms, input logic [MB-1:0] tdi,
                         input bit trst, input int half);
        wait_ready();
        cmd_len_i     = LW'(len_in);
        cmd_tms_i     = tms;
        cmd_tdi_i     = tdi;
        cmd_trst_i    = trst;
        half_period_i = DW'(half);
        cmd_valid_i   = 1'b1;
        step();
        // Scramble the command inputs: the DUT must have latched them at acceptance.
        cmd_valid_i   = 1'b0;
        cmd_len_i     = LW'($urandom);
        cmd_tms_i     = $urandom;
        cmd_tdi_i     = $urandom;
        cmd_trst_i    = $urandom_range(0, 1);
        half_period_i = DW'($urandom);
    endtask

    task automatic run_cmd(input int len_in, input logic [MB-1:0] tms, input logic [MB-1:0] tdi,
                           input bit trst, input int half, input int rsp_wait,
                           input bit use_pat, input logic [MB-1:0] tdo_pat);
        int l, h, t_end, idx, k, pulses;
        logic r;
        logic [MB-1:0] exp_tdo, held;
        l = (len_in > MB) ? MB : len_in;
        h = (half == 0) ? 1 : half;
        exp_tdo = '0;
        pulses = 0;
        offer(len_in, tms, tdi, trst, half);
        if (trst) begin
            t_end = 2 * h;
            for (int t = 0; t <= t_end; t++) begin
                check_eq($sformatf("trst@%0d", t), trst_o, (t < t_end) ? 1'b0 : 1'b1);
                check_eq($sformatf("trst_tck@%0d", t), tck_o, 1'b0);
                check_eq($sformatf("trst_valid@%0d", t), rsp_valid_o, (t == t_end));
                if (t < t_end) step();
            end
            l = 0;
        end else if (l == 0) begin
            check_eq("len0_valid@0", rsp_valid_o, 1'b0);
            check_eq("len0_busy@0", busy_o, 1'b1);
            step();
            check_eq("len0_valid@1", rsp_valid_o, 1'b1);
            check_eq("len0_tck@1", tck_o, 1'b0);
        end else begin
            t_end = 2 * h * l;
            for (int t = 0; t <= t_end; t++) begin
                idx = t / (2 * h);
                if (idx > l - 1) idx = l - 1;
                check_eq($sformatf("tck@%0d", t), tck_o, ((t % (2 * h)) >= h) && (t < t_end));
                check_eq($sformatf("tms@%0d", t), tms_o, tms[idx]);
                check_eq($sformatf("tdi@%0d", t), tdi_o, tdi[idx]);
                check_eq($sformatf("valid@%0d", t), rsp_valid_o, (t == t_end));
                if (t < t_end) begin
                    k = (t + 1) / (2 * h);
                    if (use_pat) r = tdo_pat[(k < MB) ? k : MB - 1];
                    else         r = $urandom_range(0, 1);
                    tdo_i = r;
                    if (((t + 1) % (2 * h)) == h) begin
                        exp_tdo[k] = r;
                        pulses++;
                    end
                    step();
                end
            end
            check_eq("pulse_count", pulses, l);
        end
        exp_q.push_back(exp_tdo);
        check_eq("rsp_valid", rsp_valid_o, 1'b1);
        check_eq("rsp_len", rsp_len_o, l);
        check_eq("rsp_tdo", rsp_tdo_o, exp_q.pop_front());
        held = rsp_tdo_o;
        for (int i = 0; i < rsp_wait; i++) begin
            tdo_i = $urandom_range(0, 1);
            step();
            check_eq("hold_valid", rsp_valid_o, 1'b1);
            check_eq("hold_tdo", rsp_tdo_o, held);
            check_eq("hold_cmd_ready", cmd_ready_o, 1'b0);
        end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        check_eq("post_hs_valid", rsp_valid_o, 1'b0);
        check_eq("post_hs_cmd_ready", cmd_ready_o, 1'b1);
        check_eq("post_hs_busy", busy_o, 1'b0);
    endtask

    initial begin
        logic [MB-1:0] a, b;
        // Reset
        repeat (3) step();
        check_reset_outputs("rst");
        check_eq("rst_cmd_ready", cmd_ready_o, 1'b0);
        rst_i = 1'b0;
        step();
        check_eq("rst_exit_cmd_ready", cmd_ready_o, 1'b1);

        // Directed cases
        run_cmd(5, 32'b00110, 32'b10101, 1'b0, 2, 0, 1'b1, 32'b01010);
        run_cmd(3, 32'b101, 32'b011, 1'b0, 0, 1, 1'b0, '0);
        run_cmd(40, $urandom, $urandom, 1'b0, 1, 0, 1'b0, '0);
        run_cmd(0, 32'h0, 32'h0, 1'b1, 4, 0, 1'b0, '0);
        run_cmd(0, $urandom, $urandom, 1'b0, 3, 2, 1'b0, '0);
        run_cmd(4, $urandom, $urandom, 1'b0, 1, 10, 1'b0, '0);

        // Reset during bit 2 of an 8-bit shift
        offer(8, $urandom, $urandom, 1'b0, 2);
        repeat (9) step();
        rst_i = 1'b1;
        step();
        check_reset_outputs("abort");
        check_eq("abort_cmd_ready", cmd_ready_o, 1'b0);
        rst_i = 1'b0;
        step();
        check_eq("abort_after_cmd_ready", cmd_ready_o, 1'b1);
        check_eq("abort_after_valid", rsp_valid_o, 1'b0);
        run_cmd(6, 32'b110010, 32'b011101, 1'b0, 2, 0, 1'b0, '0);

        // Random commands
        for (int i = 0; i < 25; i++) begin
            a = $urandom;
            b = $urandom;
            run_cmd($urandom_range(0, 40), a, b, ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'b0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
